// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's M-stage load/store interface. It handles one
// transaction at a time, adds a programmable number of wait states and applies byte strobes.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] busy_cycles
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  wait_cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic [15:0] busy_cycles_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic [31:0]   offset_s;
    logic [AW-1:0] idx_s;
    logic          acc_err_s;
    logic          access_s;
    logic          write_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Decode the latched address; the access fires on the edge where the wait count hits zero
    always_comb begin
        offset_s  = addr_r - BASE_ADDR;
        acc_err_s = (addr_r[1:0] != 2'b00) || (offset_s >= SPAN);
        idx_s     = offset_s[AW+1:2];
        access_s  = (state_r == ST_WAIT) && (wait_cnt_r == 4'd0);
        write_s   = access_s && we_r && !acc_err_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, transaction latch and registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 4'd0;
            we_r          <= 1'b0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            wstrb_r       <= 4'd0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= 32'd0;
            busy_cycles_r <= 16'd0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r       <= req_we;
                        addr_r     <= req_addr;
                        wdata_r    <= req_wdata;
                        wstrb_r    <= req_wstrb;
                        wait_cnt_r <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (busy_cycles_r != 16'hFFFF) begin
                        busy_cycles_r <= busy_cycles_r + 16'd1;
                    end
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else begin
                        rsp_err_r   <= acc_err_s;
                        rsp_rdata_r <= (we_r || acc_err_s) ? 32'd0 : mem_r[idx_s];
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage keeps its contents through reset; state_r gating blocks writes while reset is held
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata_r, wstrb_r);
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign busy_cycles = busy_cycles_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. It uses a byte-addressed memory model,
// a table of vectors, hand-written corner sequences and randomized traffic.
module tb_data_mem_responder;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] busy_cycles;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [4*DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] erd;
        logic        eer;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference behaviour on a flat byte array, applied in request order
    task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd, output logic er);
        logic [31:0] off;
        off = addr - BASE;
        rd  = 32'd0;
        er  = 1'b0;
        if ((addr % 32'd4) != 32'd0 || off >= 32'(4*DEPTH)) begin
            er = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mb[off + 32'(b)] = wd[8*b +: 8];
            end
        end else begin
            rd = {mb[off+32'd3], mb[off+32'd2], mb[off+32'd1], mb[off]};
        end
    endtask

    task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input int hold,
                       input bit scr, input logic [31:0] exp_rd, input logic exp_er);
        int lat;
        @(negedge clk);
        chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        @(posedge clk); #1;
        if (!scr) req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (scr) begin
                req_addr  = $urandom;
                req_we    = 1'($urandom_range(0, 1));
                req_wdata = $urandom;
                req_wstrb = 4'hF;
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'(LAT));
        chk({nm, ".rdata"}, rsp_rdata, exp_rd);
        chk({nm, ".err"}, 32'(rsp_err), 32'(exp_er));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, ".hold_rdata"}, rsp_rdata, exp_rd);
            chk({nm, ".hold_err"}, 32'(rsp_err), 32'(exp_er));
            chk({nm, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, ".post_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".post_rdata"}, rsp_rdata, 32'd0);
        chk({nm, ".post_err"}, 32'(rsp_err), 32'd0);
        chk({nm, ".post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input int hold, input bit scr);
        logic [31:0] e;
        logic        ee;
        model_op(we, addr, wd, strb, e, ee);
        txn(nm, we, addr, wd, strb, hold, scr, e, ee);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, ".rsp_err"}, 32'(rsp_err), 32'd0);
        chk({nm, ".busy"}, 32'(busy_cycles), 32'd0);
    endtask

    initial begin
        logic [31:0] e;
        logic        ee;
        logic [31:0] a;
        int          n;

        clk = 1'b0; rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk); rst = 1'b1;

        run("st_dead", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        txn("ld_dead", 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        model_op(1'b0, 32'h10, 32'd0, 4'h0, e, ee);
        chk("busy_after_two", 32'(busy_cycles), 32'd4);

        run("st_part", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0);
        txn("ld_part", 1'b0, 32'h10, 32'd0, 4'hF, 0, 1'b0, 32'hDEADBEAA, 1'b0);
        txn("ld_misal", 1'b0, 32'h12, 32'd0, 4'h0, 0, 1'b0, 32'd0, 1'b1);
        txn("ld_oor", 1'b0, 32'(4*DEPTH), 32'd0, 4'h0, 0, 1'b0, 32'd0, 1'b1);
        txn("ld_after_err", 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, 32'hDEADBEAA, 1'b0);
        txn("ld_hold5", 1'b0, 32'h10, 32'd0, 4'h0, 5, 1'b0, 32'hDEADBEAA, 1'b0);

        tbl[0]  = '{1'b1, 32'h00, 32'h11223344, 4'hF,    32'h0,        1'b0};
        tbl[1]  = '{1'b1, 32'h00, 32'h0000AB00, 4'b0010, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 32'h00, 32'h0,        4'h0,    32'h1122AB44, 1'b0};
        tbl[3]  = '{1'b1, 32'h04, 32'hCAFEF00D, 4'hF,    32'h0,        1'b0};
        tbl[4]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h04, 32'h0,        4'hF,    32'hCAFEF00D, 1'b0};
        tbl[6]  = '{1'b1, 32'hFC, 32'h87654321, 4'hF,    32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'hFC, 32'h0,        4'h0,    32'h87654321, 1'b0};
        tbl[8]  = '{1'b1, 32'h100, 32'h12345678, 4'hF,   32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h03, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h00, 32'h0,        4'h0,    32'h1122AB44, 1'b0};
        tbl[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,  4'h0,    32'h0,        1'b1};
        for (int i = 0; i < 12; i++) begin
            model_op(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].strb, e, ee);
            txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].strb,
                0, 1'b0, tbl[i].erd, tbl[i].eer);
        end

        for (int w = 0; w < DEPTH; w++) begin
            run("init", 1'b1, 32'(4*w), $urandom, 4'hF, 0, 1'b0);
        end

        run("scr_ld", 1'b0, 32'h40, 32'd0, 4'h0, 0, 1'b1);
        run("scr_st", 1'b1, 32'h44, 32'h600DCAFE, 4'hF, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("scr_no_extra_rsp", 32'(rsp_valid), 32'd0);
        end
        run("scr_chk", 1'b0, 32'h44, 32'd0, 4'h0, 0, 1'b0);

        model_op(1'b0, 32'h20, 32'd0, 4'h0, e, ee);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555AAAA; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_wait.in_wait", 32'(req_ready), 32'd0);
        #3 rst = 1'b0;
        #1 chk_reset_outputs("rst_wait");
        @(negedge clk); @(negedge clk); rst = 1'b1;
        txn("rst_wait.ld", 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0, e, 1'b0);

        model_op(1'b1, 32'h24, 32'h0BADF00D, 4'hF, e, ee);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_resp.reached", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_resp");
        @(negedge clk); rst = 1'b1;
        txn("rst_resp.ld", 1'b0, 32'h24, 32'd0, 4'h0, 0, 1'b0, 32'h0BADF00D, 1'b0);

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 9);
            a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            if (n == 0) a = a | 32'($urandom_range(1, 3));
            if (n == 1) a = a + 32'(4*DEPTH);
            run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
